button_position_calc: RTL and testbench
=======================================

# button_position_calc

Downstream consumer of the gain-trimmed button magnitudes. On each sample strobe it captures the four trimmed magnitudes, forms sum and difference terms, and computes normalised X, Y and skew (Q) positions as signed fractions with one shared bit-serial restoring divider. It sits between the gain trim stage and the position readout/decimation logic. Results are presented with a one-cycle strobe.

## Interface
- `MAG_WIDTH`, 26: width of each unsigned trimmed magnitude.
- `POS_WIDTH`, 24: width of each signed position output, Q1.(POS_WIDTH-1) format.
- `DROP_WIDTH`, 16: width of the dropped-sample counter.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `trimmedStrobe`  in  1  sample-valid strobe from the trim stage.
- `trimmed`  in  4*MAG_WIDTH  magnitudes: A=[0+:M], B=[M+:M], C=[2M+:M], D=[3M+:M].
- `clearDropped`  in  1  synchronous clear of `droppedCount`.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `positionStrobe`  out  1  one-cycle pulse when `sum`/`x`/`y`/`q` update.
- `sum`  out  MAG_WIDTH+2  A+B+C+D, unsigned.
- `x`  out  POS_WIDTH  signed ((A+D)-(B+C))/sum.
- `y`  out  POS_WIDTH  signed ((A+B)-(C+D))/sum.
- `q`  out  POS_WIDTH  signed ((A+C)-(B+D))/sum.
- `droppedCount`  out  DROP_WIDTH  saturating count of rejected samples.

## Operation
- Sample acceptance on rising edge of `trimmedStrobe` (strobe=1, registered previous=0). A strobe held high for several cycles is one sample.
- Rising edge while `busy`=1 (including the DONE cycle): sample ignored, `droppedCount` +1, saturating at all-ones. `clearDropped` has priority over an increment in the same cycle.
- FSM: IDLE -> LATCH -> DIV_X -> DIV_Y -> [DIV_Q] -> DONE -> IDLE.
  - LATCH (1 cycle): register S (MAG_WIDTH+2 bits, unsigned) and the three differences (MAG_WIDTH+3 bits, signed). No overflow is possible at these widths.
  - DIV_* (K = POS_WIDTH-1 cycles each): restoring division of |diff| by S.
    - Remainder r = |diff| initially. Each cycle: r <<= 1; if r >= S then quotient bit = 1 and r -= S.
    - Quotient is K fraction bits, MSB first. The sign is applied at the end: result = diff<0 ? -quotient : quotient.
    - Result truncates toward zero.
  - |diff| = S yields all-ones magnitude, i.e. ±(2^(POS_WIDTH-1)-1). No extra saturation logic is needed, and -2^(POS_WIDTH-1) is never produced.
  - S = 0: the division cycles still run (fixed latency), but results are forced to 0.
  - DONE (1 cycle): `sum`, `x`, `y`, `q` load together; `positionStrobe`=1.
- Outputs hold their values between DONE cycles.
- Reset (asynchronous, any state):
  - FSM goes to IDLE; strobe history and divider registers clear.
  - All outputs go to 0: `busy`, `positionStrobe`, `sum`, `x`, `y`, `q`, `droppedCount`.
  - An in-flight computation is discarded with no strobe. After release, the first rising edge is accepted normally.

## Timing
- Rising edge sampled at clock edge n: `busy`=1 from edge n+1. LATCH occupies edge n+1, divisions occupy edges n+2 onward, DONE is registered at edge n+L.
- Latency L = 3K+2 = 71 cycles with Q (POS_WIDTH=24), or 2K+2 = 48 without Q.
- `positionStrobe` and the new outputs appear after edge n+L; `busy` drops at edge n+L+1.
- Minimum accepted sample spacing: L+1 cycles between accepted rising edges.
- `trimmed` is sampled only at the accepting edge. Later changes to `trimmed` do not affect the running computation.

## Configuration
- `POSITION_Q_EN` defined: DIV_Q state is present and `q` is computed; L = 3K+2.
- `POSITION_Q_EN` undefined: DIV_Q and its difference register are omitted, DIV_Y goes directly to DONE, `q` is held at 0, and L = 2K+2.

## Test plan
All values use POS_WIDTH=24 with `POSITION_Q_EN` defined unless stated otherwise.
- Centred beam: A=B=C=D=1000 -> `sum`=4000, x=y=q=0, `positionStrobe` exactly 71 cycles after the strobe edge.
- Offset: A=D=3000, B=C=1000 -> `sum`=8000, x=4194304 (0.5), y=0, q=0.
- Single button at full scale: A=2^26-1, others 0 -> x=y=q=8388607. Then B only -> x=-8388607, y=8388607, q=-8388607.
- All zero: A=B=C=D=0 -> `sum`=0, x=y=q=0, strobe still at 71 cycles.
- Overrun and strobe width:
  - Strobe held 2 cycles -> one result.
  - Second rising edge 10 cycles after the first -> one result, `droppedCount`=1.
  - `clearDropped` -> `droppedCount`=0.
- Reset and macro off:
  - `rst_n` low at cycle 30 of a computation -> all outputs 0, no `positionStrobe`; the next sample completes normally.
  - Rebuild with `POSITION_Q_EN` undefined -> latency 48, q=0.

Source files
------------

// File: rtl/button_position_calc_if.sv
// Sample-in / position-out bundle for button_position_calc.
// The trim stage drives the master side; the position calculator is the slave.
interface button_position_calc_if #(
    parameter int MAG_WIDTH  = 26,
    parameter int POS_WIDTH  = 24,
    parameter int DROP_WIDTH = 16
);
    logic                        trimmedStrobe;
    logic [4*MAG_WIDTH-1:0]      trimmed;
    logic                        clearDropped;
    logic                        busy;
    logic                        positionStrobe;
    logic [MAG_WIDTH+1:0]        sum;
    logic signed [POS_WIDTH-1:0] x;
    logic signed [POS_WIDTH-1:0] y;
    logic signed [POS_WIDTH-1:0] q;
    logic [DROP_WIDTH-1:0]       droppedCount;

    modport master (
        output trimmedStrobe, trimmed, clearDropped,
        input  busy, positionStrobe, sum, x, y, q, droppedCount
    );

    modport slave (
        input  trimmedStrobe, trimmed, clearDropped,
        output busy, positionStrobe, sum, x, y, q, droppedCount
    );
endinterface

// File: rtl/button_position_calc.sv
// Normalised X/Y/Q beam position from four button magnitudes using one shared restoring divider.
// Define POSITION_Q_EN to build the skew (Q) division; otherwise q is held at zero.
module button_position_calc #(
    parameter int MAG_WIDTH  = 26,
    parameter int POS_WIDTH  = 24,
    parameter int DROP_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    button_position_calc_if.slave bus
);
    localparam int K  = POS_WIDTH - 1;
    localparam int SW = MAG_WIDTH + 2;
    localparam int DW = MAG_WIDTH + 3;
    localparam int CW = $clog2(K + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(K - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        DIV_X,
        DIV_Y,
`ifdef POSITION_Q_EN
        DIV_Q,
`endif
        DONE
    } state_t;

    state_t                      state_q, state_d;
    logic                        strobePrev_q, strobePrev_d;
    logic [4*MAG_WIDTH-1:0]      magCap_q, magCap_d;
    logic [SW-1:0]               sumReg_q, sumReg_d;
    logic signed [DW-1:0]        diffX_q, diffX_d;
    logic signed [DW-1:0]        diffY_q, diffY_d;
    logic [SW-1:0]               rem_q, rem_d;
    logic [K-1:0]                quot_q, quot_d;
    logic [CW-1:0]               bitCnt_q, bitCnt_d;
    logic signed [POS_WIDTH-1:0] resX_q, resX_d;
    logic signed [POS_WIDTH-1:0] resY_q, resY_d;
    logic [SW-1:0]               sumOut_q, sumOut_d;
    logic signed [POS_WIDTH-1:0] xOut_q, xOut_d;
    logic signed [POS_WIDTH-1:0] yOut_q, yOut_d;
    logic                        strobeOut_q, strobeOut_d;
    logic                        busy_q, busy_d;
    logic [DROP_WIDTH-1:0]       dropped_q, dropped_d;
`ifdef POSITION_Q_EN
    logic signed [DW-1:0]        diffQ_q, diffQ_d;
    logic signed [POS_WIDTH-1:0] resQ_q, resQ_d;
    logic signed [POS_WIDTH-1:0] qOut_q, qOut_d;
    logic signed [DW-1:0]        diffQCalc;
`endif

    logic                 rise;
    logic                 accept;
    logic                 drop;
    logic                 lastBit;
    logic                 sumZero;
    logic [SW-1:0]        magA, magB, magC, magD;
    logic [SW-1:0]        sumCalc;
    logic signed [DW-1:0] diffXCalc, diffYCalc;
    logic [DW-1:0]        remShift;
    logic [DW-1:0]        divisor;
    logic [SW-1:0]        remSub;
    logic                 quoBit;
    logic [K-1:0]         quotStep;

    function automatic logic [SW-1:0] absMag(input logic signed [DW-1:0] v);
        return SW'(v[DW-1] ? -v : v);
    endfunction

    // Quotient is a pure magnitude; sign is applied last so results truncate toward zero.
    function automatic logic signed [POS_WIDTH-1:0] applySign(
        input logic         neg,
        input logic         zero,
        input logic [K-1:0] mag
    );
        logic signed [POS_WIDTH-1:0] pos;
        pos = {1'b0, mag};
        if (zero) begin
            return '0;
        end
        return neg ? -pos : pos;
    endfunction

    assign rise    = bus.trimmedStrobe & ~strobePrev_q;
    assign accept  = rise && (state_q == IDLE);
    assign drop    = rise && (state_q != IDLE);
    assign lastBit = (bitCnt_q == LAST_BIT);
    assign sumZero = (sumReg_q == '0);

    assign magA = SW'(magCap_q[0*MAG_WIDTH +: MAG_WIDTH]);
    assign magB = SW'(magCap_q[1*MAG_WIDTH +: MAG_WIDTH]);
    assign magC = SW'(magCap_q[2*MAG_WIDTH +: MAG_WIDTH]);
    assign magD = SW'(magCap_q[3*MAG_WIDTH +: MAG_WIDTH]);

    assign sumCalc   = magA + magB + magC + magD;
    assign diffXCalc = $signed((DW'(magA) + DW'(magD)) - (DW'(magB) + DW'(magC)));
    assign diffYCalc = $signed((DW'(magA) + DW'(magB)) - (DW'(magC) + DW'(magD)));
`ifdef POSITION_Q_EN
    assign diffQCalc = $signed((DW'(magA) + DW'(magC)) - (DW'(magB) + DW'(magD)));
`endif

    // Remainder never exceeds the divisor, so the low SW bits of the subtraction are exact.
    assign remShift = {rem_q, 1'b0};
    assign divisor  = {1'b0, sumReg_q};
    assign quoBit   = (remShift >= divisor);
    assign remSub   = remShift[SW-1:0] - sumReg_q;
    assign quotStep = {quot_q[K-2:0], quoBit};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept) state_d = LATCH;
            LATCH: state_d = DIV_X;
            DIV_X: if (lastBit) state_d = DIV_Y;
`ifdef POSITION_Q_EN
            DIV_Y: if (lastBit) state_d = DIV_Q;
            DIV_Q: if (lastBit) state_d = DONE;
`else
            DIV_Y: if (lastBit) state_d = DONE;
`endif
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        strobePrev_d = bus.trimmedStrobe;
        magCap_d     = magCap_q;
        sumReg_d     = sumReg_q;
        diffX_d      = diffX_q;
        diffY_d      = diffY_q;
        rem_d        = rem_q;
        quot_d       = quot_q;
        bitCnt_d     = bitCnt_q;
        resX_d       = resX_q;
        resY_d       = resY_q;
`ifdef POSITION_Q_EN
        diffQ_d      = diffQ_q;
        resQ_d       = resQ_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) magCap_d = bus.trimmed;
            end
            LATCH: begin
                sumReg_d = sumCalc;
                diffX_d  = diffXCalc;
                diffY_d  = diffYCalc;
`ifdef POSITION_Q_EN
                diffQ_d  = diffQCalc;
`endif
                rem_d    = absMag(diffXCalc);
                quot_d   = '0;
                bitCnt_d = '0;
            end
`ifdef POSITION_Q_EN
            DIV_X, DIV_Y, DIV_Q: begin
`else
            DIV_X, DIV_Y: begin
`endif
                rem_d    = quoBit ? remSub : remShift[SW-1:0];
                quot_d   = quotStep;
                bitCnt_d = bitCnt_q + 1'b1;
                // On the final bit, store the signed result and seed the next division.
                if (lastBit) begin
                    quot_d   = '0;
                    bitCnt_d = '0;
                    if (state_q == DIV_X) begin
                        resX_d = applySign(diffX_q[DW-1], sumZero, quotStep);
                        rem_d  = absMag(diffY_q);
                    end else if (state_q == DIV_Y) begin
                        resY_d = applySign(diffY_q[DW-1], sumZero, quotStep);
`ifdef POSITION_Q_EN
                        rem_d  = absMag(diffQ_q);
                    end else begin
                        resQ_d = applySign(diffQ_q[DW-1], sumZero, quotStep);
`endif
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        sumOut_d    = sumOut_q;
        xOut_d      = xOut_q;
        yOut_d      = yOut_q;
`ifdef POSITION_Q_EN
        qOut_d      = qOut_q;
`endif
        strobeOut_d = 1'b0;
        busy_d      = (state_q != IDLE);
        dropped_d   = dropped_q;
        if (state_q == DONE) begin
            sumOut_d    = sumReg_q;
            xOut_d      = resX_q;
            yOut_d      = resY_q;
`ifdef POSITION_Q_EN
            qOut_d      = resQ_q;
`endif
            strobeOut_d = 1'b1;
        end
        if (bus.clearDropped) begin
            dropped_d = '0;
        end else if (drop && (dropped_q != '1)) begin
            dropped_d = dropped_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            strobePrev_q <= 1'b0;
            magCap_q     <= '0;
            sumReg_q     <= '0;
            diffX_q      <= '0;
            diffY_q      <= '0;
            rem_q        <= '0;
            quot_q       <= '0;
            bitCnt_q     <= '0;
            resX_q       <= '0;
            resY_q       <= '0;
            sumOut_q     <= '0;
            xOut_q       <= '0;
            yOut_q       <= '0;
            strobeOut_q  <= 1'b0;
            busy_q       <= 1'b0;
            dropped_q    <= '0;
`ifdef POSITION_Q_EN
            diffQ_q      <= '0;
            resQ_q       <= '0;
            qOut_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            strobePrev_q <= strobePrev_d;
            magCap_q     <= magCap_d;
            sumReg_q     <= sumReg_d;
            diffX_q      <= diffX_d;
            diffY_q      <= diffY_d;
            rem_q        <= rem_d;
            quot_q       <= quot_d;
            bitCnt_q     <= bitCnt_d;
            resX_q       <= resX_d;
            resY_q       <= resY_d;
            sumOut_q     <= sumOut_d;
            xOut_q       <= xOut_d;
            yOut_q       <= yOut_d;
            strobeOut_q  <= strobeOut_d;
            busy_q       <= busy_d;
            dropped_q    <= dropped_d;
`ifdef POSITION_Q_EN
            diffQ_q      <= diffQ_d;
            resQ_q       <= resQ_d;
            qOut_q       <= qOut_d;
`endif
        end
    end

    assign bus.busy           = busy_q;
    assign bus.positionStrobe = strobeOut_q;
    assign bus.sum            = sumOut_q;
    assign bus.x              = xOut_q;
    assign bus.y              = yOut_q;
    assign bus.droppedCount   = dropped_q;
`ifdef POSITION_Q_EN
    assign bus.q              = qOut_q;
`else
    assign bus.q              = '0;
`endif
endmodule

// File: tb/tb_button_position_calc.sv
// Scoreboard bench for button_position_calc: expected positions come from an integer-division model.
module tb_button_position_calc;
    localparam int MW  = 26;
    localparam int PW  = 24;
    localparam int DRW = 16;
    localparam int K   = PW - 1;
`ifdef POSITION_Q_EN
    localparam int LAT = 3 * K + 2;
`else
    localparam int LAT = 2 * K + 2;
`endif
    localparam longint FULL = 64'd67108863;

    typedef struct {
        longint sum;
        longint x;
        longint y;
        longint q;
        longint expEdge;
    } expect_t;

    logic   clk;
    logic   rst_n;
    longint cycleCount;
    int     errorCount;
    int     checkCount;
    expect_t sbQ[$];

    button_position_calc_if #(.MAG_WIDTH(MW), .POS_WIDTH(PW), .DROP_WIDTH(DRW)) bus ();

    button_position_calc #(.MAG_WIDTH(MW), .POS_WIDTH(PW), .DROP_WIDTH(DRW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cycleCount = 0;
    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cycleCount);
        end
    endtask

    function automatic longint expPos(input longint diff, input longint s);
        longint mag;
        longint quo;
        if (s == 0) return 0;
        mag = (diff < 0) ? -diff : diff;
        quo = (mag << K) / s;
        if (quo > ((longint'(1) << K) - 1)) quo = (longint'(1) << K) - 1;
        return (diff < 0) ? -quo : quo;
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Raises the strobe for holdCycles, then scrambles trimmed to prove it was captured once.
    task automatic applyStimulus(input longint a, input longint b, input longint c, input longint d,
                                 input int holdCycles, input bit expectResult);
        expect_t      e;
        logic [127:0] junk;
        bus.trimmed       = {MW'(d), MW'(c), MW'(b), MW'(a)};
        bus.trimmedStrobe = 1'b1;
        if (expectResult) begin
            e.sum = a + b + c + d;
            e.x   = expPos((a + d) - (b + c), e.sum);
            e.y   = expPos((a + b) - (c + d), e.sum);
`ifdef POSITION_Q_EN
            e.q   = expPos((a + c) - (b + d), e.sum);
`else
            e.q   = 0;
`endif
            e.expEdge = cycleCount + 1 + LAT;
            sbQ.push_back(e);
        end
        repeat (holdCycles) stepCycle();
        bus.trimmedStrobe = 1'b0;
        junk = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.trimmed = junk[4*MW-1:0];
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        while ((sbQ.size() != 0 || bus.busy) && n < 300) begin
            stepCycle();
            n++;
        end
        if (n >= 300) checkOutput("waitTimeout", n, 0);
    endtask

    task automatic checkAllZero(input string phase);
        checkOutput({phase, ".sum"}, longint'(bus.sum), 0);
        checkOutput({phase, ".x"}, longint'(bus.x), 0);
        checkOutput({phase, ".y"}, longint'(bus.y), 0);
        checkOutput({phase, ".q"}, longint'(bus.q), 0);
        checkOutput({phase, ".busy"}, longint'(bus.busy), 0);
        checkOutput({phase, ".strobe"}, longint'(bus.positionStrobe), 0);
        checkOutput({phase, ".dropped"}, longint'(bus.droppedCount), 0);
    endtask

    always @(posedge clk) begin
        expect_t e;
        #1;
        if (bus.positionStrobe === 1'b1) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpectedStrobe", 1, 0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("latency", cycleCount, e.expEdge);
                checkOutput("sum", longint'(bus.sum), e.sum);
                checkOutput("x", longint'(bus.x), e.x);
                checkOutput("y", longint'(bus.y), e.y);
                checkOutput("q", longint'(bus.q), e.q);
            end
        end
    end

    initial begin
        errorCount        = 0;
        checkCount        = 0;
        bus.trimmedStrobe = 1'b0;
        bus.trimmed       = '0;
        bus.clearDropped  = 1'b0;
        rst_n             = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) stepCycle();
        checkAllZero("reset");
        rst_n = 1'b1;
        stepCycle();

        applyStimulus(1000, 1000, 1000, 1000, 1, 1);
        stepCycle();
        checkOutput("busyDuring", longint'(bus.busy), 1);
        waitDone();
        checkOutput("busyAfter", longint'(bus.busy), 0);

        applyStimulus(3000, 1000, 1000, 3000, 1, 1);
        waitDone();
        applyStimulus(FULL, 0, 0, 0, 1, 1);
        waitDone();
        applyStimulus(0, FULL, 0, 0, 1, 1);
        waitDone();
        applyStimulus(0, 0, 0, 0, 1, 1);
        waitDone();

        applyStimulus(5000, 2000, 700, 123, 2, 1);
        waitDone();

        applyStimulus(40000, 10, 20000, 5, 1, 1);
        repeat (9) stepCycle();
        applyStimulus(1, 2, 3, 4, 1, 0);
        waitDone();
        checkOutput("droppedOne", longint'(bus.droppedCount), 1);
        bus.clearDropped = 1'b1;
        stepCycle();
        bus.clearDropped = 1'b0;
        checkOutput("droppedCleared", longint'(bus.droppedCount), 0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(longint'($urandom()) & FULL, longint'($urandom()) & FULL,
                          longint'($urandom_range(5000, 0)), longint'($urandom()) & FULL, 1, 1);
            waitDone();
        end

        applyStimulus(7, 8, 9, 10, 1, 0);
        repeat (9) stepCycle();
        applyStimulus(1, 1, 1, 1, 1, 0);
        repeat (19) stepCycle();
        checkOutput("droppedBeforeReset", longint'(bus.droppedCount), 1);
        rst_n = 1'b0;
        #2;
        checkAllZero("midReset");
        stepCycle();
        rst_n = 1'b1;
        repeat (LAT + 10) stepCycle();
        checkOutput("idleAfterReset", longint'(bus.busy), 0);

        applyStimulus(2500, 500, 1500, 100, 1, 1);
        waitDone();
        checkOutput("pendingResults", sbQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule
